// File: rtl/imm_extend_pipe.sv
// Registered immediate extender between decode and execute.
// Valid/ready handshake with a one-entry skid buffer; in_ready depends only on skid occupancy.
module imm_extend_pipe #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_neg
);

    function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                                input logic [1:0]      mode);
        logic signed [IN_W-1:0]  simm;
        logic signed [OUT_W-1:0] sx;
        simm = imm;
        sx   = OUT_W'(simm);
        case (mode)
            2'd0:    extend = sx;
            2'd1:    extend = OUT_W'(imm);
            2'd2:    extend = OUT_W'(imm) << (OUT_W - IN_W);
            default: extend = sx << BR_SHIFT;
        endcase
    endfunction

    logic [OUT_W-1:0] ext_p0;
    logic             vld_p0;
    logic [OUT_W-1:0] data_p0;
    logic             vld_p1;
    logic [OUT_W-1:0] data_p1;
    logic             neg_p1;
    logic             accept;
    logic             pop;

    assign ext_p0 = extend(in_imm, in_mode);
    assign accept = in_valid && !vld_p0;
    assign pop    = vld_p1 && out_ready;

    // p0 (skid) -> p1 (output register)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            neg_p1  <= 1'b0;
        end else if (flush) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else if (!vld_p1 || pop) begin
            if (vld_p0) begin
                data_p1 <= data_p0;
                neg_p1  <= data_p0[OUT_W-1];
                vld_p1  <= 1'b1;
                vld_p0  <= 1'b0;
            end else if (accept) begin
                data_p1 <= ext_p0;
                neg_p1  <= ext_p0[OUT_W-1];
                vld_p1  <= 1'b1;
            end else begin
                vld_p1 <= 1'b0;
            end
        end else if (accept) begin
            data_p0 <= ext_p0;
            vld_p0  <= 1'b1;
        end
    end

    assign in_ready  = !vld_p0;
    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_neg   = neg_p1;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: vector table, scoreboard queue and handshake corner sequences.
module tb_imm_extend_pipe;

    typedef struct {
        logic [15:0] imm;
        logic [1:0]  mode;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0]  imm;
        logic [1:0]  mode;
        logic [15:0] exp;
    } vvec_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_neg;

    logic        v_flush;
    logic        v_in_valid;
    logic        v_in_ready;
    logic [7:0]  v_in_imm;
    logic [1:0]  v_in_mode;
    logic        v_out_valid;
    logic        v_out_ready;
    logic [15:0] v_out_data;
    logic        v_out_neg;

    logic [31:0] drv_exp;
    logic [31:0] sbq[$];
    int          nvec;
    int          nerr;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .BR_SHIFT(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_neg(out_neg)
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(16), .BR_SHIFT(1)) dut_v (
        .clk(clk), .rst_n(rst_n), .flush(v_flush),
        .in_valid(v_in_valid), .in_ready(v_in_ready), .in_imm(v_in_imm), .in_mode(v_in_mode),
        .out_valid(v_out_valid), .out_ready(v_out_ready), .out_data(v_out_data), .out_neg(v_out_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: older output popped before a same-cycle accepted input is pushed.
    always @(negedge clk) begin
        if (rst_n) begin
            if (flush) begin
                sbq.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sbq.size() == 0) begin
                        check("sb_unexpected_output", out_data, 32'hDEAD_BEEF);
                    end else begin
                        logic [31:0] e;
                        e = sbq.pop_front();
                        check("sb_data", out_data, e);
                        check("sb_neg", 32'(out_neg), 32'(e[31]));
                    end
                end
                if (in_valid && in_ready) sbq.push_back(drv_exp);
            end
        end
    end

    task automatic put(input logic [15:0] imm, input logic [1:0] mode, input logic [31:0] exp);
        bit acc;
        int n;
        in_imm   = imm;
        in_mode  = mode;
        drv_exp  = exp;
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) check("put_timeout", 32'(acc), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t  tbl[5];
        vvec_t vtbl[3];
        tbl[0] = '{16'h8001, 2'd0, 32'hFFFF_8001};
        tbl[1] = '{16'h8001, 2'd1, 32'h0000_8001};
        tbl[2] = '{16'h8001, 2'd2, 32'h8001_0000};
        tbl[3] = '{16'hFFFF, 2'd3, 32'hFFFF_FFFC};
        tbl[4] = '{16'h0004, 2'd3, 32'h0000_0010};
        vtbl[0] = '{8'h80, 2'd0, 16'hFF80};
        vtbl[1] = '{8'h80, 2'd2, 16'h8000};
        vtbl[2] = '{8'h80, 2'd3, 16'hFF00};

        nvec = 0;
        nerr = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_imm = '0;
        in_mode = '0;
        out_ready = 1'b1;
        drv_exp = '0;
        v_flush = 1'b0;
        v_in_valid = 1'b0;
        v_in_imm = '0;
        v_in_mode = '0;
        v_out_ready = 1'b1;

        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_neg", 32'(out_neg), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Modes: each result visible right after its accept edge.
        for (int i = 0; i < 5; i++) begin
            put(tbl[i].imm, tbl[i].mode, tbl[i].exp);
            check("mode_valid", 32'(out_valid), 32'd1);
            check("mode_data", out_data, tbl[i].exp);
            check("mode_neg", 32'(out_neg), 32'(tbl[i].exp[31]));
        end

        // Back-to-back throughput.
        for (int i = 0; i < 8; i++) begin
            put(16'(i), 2'd0, 32'(i));
            check("thr_data", out_data, 32'(i));
            check("thr_in_ready", 32'(in_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // Back-pressure: A in OR, B in skid, C held off.
        out_ready = 1'b0;
        put(16'h7FFF, 2'd0, 32'h0000_7FFF);
        put(16'h8000, 2'd0, 32'hFFFF_8000);
        check("bp_or_data", out_data, 32'h0000_7FFF);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        in_imm = 16'h0123;
        in_mode = 2'd0;
        drv_exp = 32'h0000_0123;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_data", out_data, 32'h0000_7FFF);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_b_data", out_data, 32'hFFFF_8000);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_c_data", out_data, 32'h0000_0123);
        @(posedge clk);
        #1;
        check("bp_drained_valid", 32'(out_valid), 32'd0);

        // Flush with OR and skid full and an input presented.
        out_ready = 1'b0;
        put(16'h1111, 2'd1, 32'h0000_1111);
        put(16'h2222, 2'd1, 32'h0000_2222);
        in_imm = 16'h5555;
        in_mode = 2'd1;
        drv_exp = 32'h0000_5555;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("flush_nothing_out", 32'(out_valid), 32'd0);
        end

        // Asynchronous reset between edges with OR and skid full.
        out_ready = 1'b0;
        put(16'h3333, 2'd1, 32'h0000_3333);
        put(16'h4444, 2'd1, 32'h0000_4444);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", out_data, 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        put(16'hFFFE, 2'd0, 32'hFFFF_FFFE);
        check("arst_resume_data", out_data, 32'hFFFF_FFFE);
        check("arst_resume_neg", 32'(out_neg), 32'd1);
        @(posedge clk);
        #1;

        // Narrow parameter variant.
        for (int i = 0; i < 3; i++) begin
            v_in_imm = vtbl[i].imm;
            v_in_mode = vtbl[i].mode;
            v_in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("var_data", 32'(v_out_data), 32'(vtbl[i].exp));
            check("var_neg", 32'(v_out_neg), 32'(vtbl[i].exp[15]));
            check("var_ready", 32'({v_out_valid, v_in_ready}), 32'd3);
        end
        v_in_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, registered immediate extender for the datapath.
- Takes an IN_W-bit immediate and a 2-bit mode, and produces an OUT_W-bit operand.
- Modes: sign extend, zero extend, upper placement (LUI style) and shifted sign extend (branch offsets).
- Sits between decode and execute. Uses a valid/ready handshake with a one-entry skid buffer, so back-pressure from execute never drops or reorders immediates.

Parameters:
- IN_W, 16, immediate input width; must satisfy 1 <= IN_W <= OUT_W.
- OUT_W, 32, extended output width.
- BR_SHIFT, 2, left-shift amount for mode 3; must satisfy 0 <= BR_SHIFT < OUT_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous pipeline flush, active high.
- in_valid  input  1  immediate and mode are valid.
- in_ready  output  1  block can accept an input this cycle.
- in_imm  input  IN_W  raw immediate.
- in_mode  input  2  0 = sign, 1 = zero, 2 = upper, 3 = sign then shift by BR_SHIFT.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  OUT_W  extended result.
- out_neg  output  1  out_data[OUT_W-1], registered alongside out_data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_neg=0.
  - Skid entry invalid and zeroed; in_ready=1.
  - Any in-flight entries are discarded.
  - Operation resumes on the first clock edge after rst_n rises.
- Storage:
  - Output register OR drives out_valid, out_data and out_neg.
  - Skid register SR holds one overflow entry.
  - in_ready = !SR.valid, driven from a register and never combinational from out_ready.
- Extension, combinational before the register:
  - mode 0: replicate in_imm[IN_W-1] into the upper OUT_W-IN_W bits.
  - mode 1: upper bits zero.
  - mode 2: in_imm placed in bits [OUT_W-1 : OUT_W-IN_W], low bits zero.
  - mode 3: mode 0 result shifted left by BR_SHIFT; bits shifted past OUT_W-1 are discarded; low BR_SHIFT bits are zero.
  - If IN_W == OUT_W: modes 0, 1 and 2 all pass in_imm through unchanged.
- Accept = in_valid && in_ready. Pop = out_valid && out_ready.
- Per rising edge, in priority order:
  1. flush=1: OR.valid=0, SR.valid=0, in_ready=1 next cycle; any input presented in the same cycle is discarded.
  2. OR empty, or Pop: OR loads SR if SR is valid (SR then clears), else loads the accepted input, else OR.valid becomes 0.
  3. Accept while OR is valid and there is no Pop: the entry goes to SR, and in_ready falls the next cycle.
  4. Accept while SR is valid is impossible (in_ready=0).
- Latency: accepted input appears on out_data at the next edge (1 cycle).
- Throughput: 1 per cycle while out_ready=1.
- Data stability: out_data, out_neg and out_valid hold while out_valid=1 and out_ready=0.
- Ordering: strict FIFO; the SR entry always precedes any later input.
- Simultaneous Accept and Pop with SR empty: OR takes the new entry directly and SR stays empty.
- Data registers load only on their valid transitions, so X on in_imm while in_valid=0 is never captured.

Test Plan:
- Modes, IN_W=16, OUT_W=32, BR_SHIFT=2, out_ready=1, in_imm=0x8001:
  - mode 0 -> 0xFFFF8001, out_neg=1.
  - mode 1 -> 0x00008001, out_neg=0.
  - mode 2 -> 0x80010000.
  - mode 3 with in_imm=0xFFFF -> 0xFFFFFFFC; mode 3 with in_imm=0x0004 -> 0x00000010.
  - Each result appears one cycle after Accept.
- Throughput: 8 back-to-back inputs 0x0000..0x0007 in mode 0 with out_ready=1 -> outputs 0x00000000..0x00000007 on 8 consecutive cycles; in_ready stays 1.
- Back-pressure: out_ready=0, push A=0x7FFF then B=0x8000 (mode 0):
  - OR=0x00007FFF, SR holds B, in_ready=0; a third input C is held off.
  - Raise out_ready -> A, B, C emerge in order (C=0xFFFF8000 if C=0x8000); in_ready returns to 1 one cycle after SR drains.
- Flush with both entries valid and in_valid=1 in the flush cycle -> next cycle out_valid=0, in_ready=1, and none of the three entries ever appears.
- Reset mid-operation: rst_n low asynchronously between edges with OR and SR full -> out_valid=0, out_data=0 and in_ready=1 immediately; after release, the first new input emerges normally.
- Parameter variant IN_W=8, OUT_W=16, BR_SHIFT=1, in_imm=0x80:
  - mode 0 -> 0xFF80.
  - mode 2 -> 0x8000.
  - mode 3 -> 0xFF00.
